// File: rtl/starflux_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : starflux_pkg
//  Description: Shared widths, gun FSM state type and heat thresholds used by
//               the gun fire controller, cooldown handler and HUD.
//  Revision   : 1.0  initial release
// ============================================================================
package starflux_pkg;

    localparam int HEAT_W = 4;
    localparam int CNT_W  = 28;

    localparam logic [HEAT_W-1:0] DEFAULT_HEAT_MAX    = 4'd15;
    localparam logic [HEAT_W-1:0] DEFAULT_HEAT_RESUME = 4'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        GAP     = 2'd2,
        LOCKOUT = 2'd3
    } gun_fire_state_t;

    function automatic logic heat_at_limit(input logic [HEAT_W-1:0] heat,
                                           input logic [HEAT_W-1:0] heat_max);
        return (heat >= heat_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gun_fire_controller_if.sv
`default_nettype none
// ============================================================================
//  Interface  : gun_fire_controller_if
//  Description: Fire input, heat input and spawn handshake / HUD outputs of
//               the gun fire controller.
//  Revision   : 1.0  initial release
// ============================================================================
interface gun_fire_controller_if;
    import starflux_pkg::*;

    logic              fire_request;
    logic [HEAT_W-1:0] heat;
    logic              spawn_ack;
    logic              spawn_req;
    logic              overheated;
    logic              shot_ready;
    logic              shot_dropped;
    logic [7:0]        shots_fired;

    modport master (
        output fire_request, heat, spawn_ack,
        input  spawn_req, overheated, shot_ready, shot_dropped, shots_fired
    );

    modport slave (
        input  fire_request, heat, spawn_ack,
        output spawn_req, overheated, shot_ready, shot_dropped, shots_fired
    );

endinterface
`default_nettype wire

// File: rtl/shot_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module     : shot_interval_timer
//  Description: Loadable down counter with clear and zero flag; stops at 0.
//  Revision   : 1.0  initial release
// ============================================================================
module shot_interval_timer
    import starflux_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_value,
    input  wire logic             clear,
    input  wire logic             decrement,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (decrement && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gun_fire_controller.sv
`default_nettype none
// ============================================================================
//  Module     : gun_fire_controller
//  Description: Rate-limited projectile spawn requests with overheat lockout
//               (hysteresis), req/ack handshake with timeout, shot counter.
//  Revision   : 1.0  initial release
// ============================================================================
module gun_fire_controller
    import starflux_pkg::*;
#(
    parameter logic [HEAT_W-1:0] HEAT_MAX      = DEFAULT_HEAT_MAX,
    parameter logic [HEAT_W-1:0] HEAT_RESUME   = DEFAULT_HEAT_RESUME,
    parameter logic [CNT_W-1:0]  SHOT_INTERVAL = 28'd12_499_999,
    parameter logic [7:0]        ACK_TIMEOUT   = 8'd255
) (
    input  wire logic            clock,
    input  wire logic            reset,
    gun_fire_controller_if.slave bus
);

    localparam logic [7:0] c_shots_max = 8'd255;

    gun_fire_state_t r_state;
    gun_fire_state_t w_state_next;

    logic [7:0] r_ack_cnt;
    logic [7:0] w_ack_cnt_next;
    logic       r_spawn_req;
    logic       r_overheated;
    logic       r_shot_ready;
    logic       r_shot_dropped;
    logic [7:0] r_shots_fired;

    logic w_heat_locked;
    logic w_timer_load;
    logic w_timer_clear;
    logic w_timer_dec;
    logic w_timer_zero;
    logic w_shot_acked;
    logic w_shot_dropped;

    assign w_heat_locked = heat_at_limit(bus.heat, HEAT_MAX);

    shot_interval_timer #(
        .WIDTH (CNT_W)
    ) u_gap_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (w_timer_load),
        .load_value (SHOT_INTERVAL),
        .clear      (w_timer_clear),
        .decrement  (w_timer_dec),
        .zero       (w_timer_zero)
    );

    always_comb begin
        w_state_next   = r_state;
        w_ack_cnt_next = r_ack_cnt;
        w_timer_load   = 1'b0;
        w_timer_clear  = 1'b0;
        w_timer_dec    = 1'b0;
        w_shot_acked   = 1'b0;
        w_shot_dropped = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_heat_locked) begin
                    w_state_next = LOCKOUT;
                end else if (bus.fire_request) begin
                    w_state_next   = REQUEST;
                    w_ack_cnt_next = '0;
                end
            end
            // Heat and fire_request are deliberately ignored: the handshake
            // always finishes with an ack or a timeout.
            REQUEST: begin
                if (bus.spawn_ack) begin
                    w_state_next = GAP;
                    w_shot_acked = 1'b1;
                    w_timer_load = 1'b1;
                end else if (r_ack_cnt == ACK_TIMEOUT) begin
                    w_state_next   = GAP;
                    w_shot_dropped = 1'b1;
                    w_timer_load   = 1'b1;
                end else begin
                    w_ack_cnt_next = r_ack_cnt + 8'd1;
                end
            end
            GAP: begin
                if (w_heat_locked) begin
                    w_state_next  = LOCKOUT;
                    w_timer_clear = 1'b1;
                end else if (w_timer_zero) begin
                    w_state_next = IDLE;
                end else begin
                    w_timer_dec = 1'b1;
                end
            end
            LOCKOUT: begin
                if (bus.heat <= HEAT_RESUME) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_ack_cnt      <= '0;
            r_spawn_req    <= 1'b0;
            r_overheated   <= 1'b0;
            r_shot_ready   <= 1'b0;
            r_shot_dropped <= 1'b0;
            r_shots_fired  <= '0;
        end else begin
            r_state        <= w_state_next;
            r_ack_cnt      <= w_ack_cnt_next;
            r_spawn_req    <= (w_state_next == REQUEST);
            r_overheated   <= (w_state_next == LOCKOUT);
            r_shot_ready   <= (r_state == IDLE) && !w_heat_locked;
            r_shot_dropped <= w_shot_dropped;
            if (w_shot_acked && (r_shots_fired != c_shots_max)) begin
                r_shots_fired <= r_shots_fired + 8'd1;
            end
        end
    end

    assign bus.spawn_req    = r_spawn_req;
    assign bus.overheated   = r_overheated;
    assign bus.shot_ready   = r_shot_ready;
    assign bus.shot_dropped = r_shot_dropped;
    assign bus.shots_fired  = r_shots_fired;

endmodule
`default_nettype wire

// File: tb/tb_gun_fire_controller.sv
`default_nettype none
// ============================================================================
//  Module     : tb_gun_fire_controller
//  Description: Directed self-checking bench, SHOT_INTERVAL=3, ACK_TIMEOUT=4.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_gun_fire_controller;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycles;

    gun_fire_controller_if bus ();

    gun_fire_controller #(
        .HEAT_MAX      (4'd15),
        .HEAT_RESUME   (4'd4),
        .SHOT_INTERVAL (28'd3),
        .ACK_TIMEOUT   (8'd4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_spawn(input string tag, input int limit);
        int n;
        n = 0;
        while (!bus.spawn_req && n < limit) begin
            tick();
            n++;
        end
        check(tag, bus.spawn_req, 1'b1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.fire_request = 1'b0;
        bus.heat         = 4'd0;
        bus.spawn_ack    = 1'b0;
        tick(2);
        check("rst_spawn_req",    bus.spawn_req,    1'b0);
        check("rst_overheated",   bus.overheated,   1'b0);
        check("rst_shot_ready",   bus.shot_ready,   1'b0);
        check("rst_shot_dropped", bus.shot_dropped, 1'b0);
        check("rst_shots_fired",  bus.shots_fired,  8'd0);

        reset = 1'b0;
        tick();
        check("ready_after_rst", bus.shot_ready, 1'b1);
        check("idle_no_req",     bus.spawn_req,  1'b0);

        // Autofire with ack two cycles after each request: 8-cycle period.
        bus.fire_request = 1'b1;
        tick();
        check("req_latency", bus.spawn_req, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick(2);
            check("req_held", bus.spawn_req, 1'b1);
            bus.spawn_ack = 1'b1;
            tick();
            bus.spawn_ack = 1'b0;
            check("req_drop_on_ack", bus.spawn_req, 1'b0);
            check("shots_count",     bus.shots_fired, k);
            tick(4);
            check("gap_no_req", bus.spawn_req, 1'b0);
            tick();
            check("next_req", bus.spawn_req, 1'b1);
        end

        // No ack: request held 5 cycles, then one drop pulse.
        tick(4);
        check("to_req_held",  bus.spawn_req,    1'b1);
        check("to_no_drop",   bus.shot_dropped, 1'b0);
        tick();
        check("to_req_low",   bus.spawn_req,    1'b0);
        check("to_drop",      bus.shot_dropped, 1'b1);
        check("to_no_count",  bus.shots_fired,  8'd3);
        tick();
        check("to_drop_once", bus.shot_dropped, 1'b0);
        tick(3);
        check("to_gap",       bus.spawn_req,    1'b0);
        tick();
        check("to_next_req",  bus.spawn_req,    1'b1);

        // Ack on the same cycle the timeout is reached.
        tick(4);
        bus.spawn_ack = 1'b1;
        tick();
        bus.spawn_ack = 1'b0;
        check("race_count",   bus.shots_fired,  8'd4);
        check("race_no_drop", bus.shot_dropped, 1'b0);
        check("race_req_low", bus.spawn_req,    1'b0);

        // Lockout entered from IDLE, hysteresis on the way down.
        tick(4);
        check("idle_before_lock", bus.spawn_req, 1'b0);
        bus.heat = 4'd15;
        tick();
        check("lock_overheated", bus.overheated, 1'b1);
        check("lock_no_req",     bus.spawn_req,  1'b0);
        check("lock_not_ready",  bus.shot_ready, 1'b0);
        for (int h = 14; h >= 5; h--) begin
            bus.heat = h[3:0];
            tick();
            check("hyst_hold", bus.overheated, 1'b1);
            check("hyst_no_req", bus.spawn_req, 1'b0);
        end
        bus.heat = 4'd4;
        tick();
        check("resume_overheated", bus.overheated, 1'b0);
        check("resume_no_req",     bus.spawn_req,  1'b0);
        tick();
        check("resume_shot", bus.spawn_req, 1'b1);

        // Heat hits the limit mid-request: handshake completes, then lockout.
        tick();
        bus.heat = 4'd15;
        tick();
        check("midreq_held",      bus.spawn_req,  1'b1);
        check("midreq_not_lock",  bus.overheated, 1'b0);
        bus.spawn_ack = 1'b1;
        tick();
        bus.spawn_ack = 1'b0;
        check("midreq_count",     bus.shots_fired, 8'd5);
        check("midreq_gap",       bus.overheated,  1'b0);
        tick();
        check("gap_to_lock",      bus.overheated,  1'b1);
        bus.heat = 4'd0;
        tick();
        check("unlock",           bus.overheated,  1'b0);
        tick();
        check("unlock_shot",      bus.spawn_req,   1'b1);

        // Ack held high: one shot every 6 cycles until the counter saturates.
        bus.spawn_ack = 1'b1;
        cycles = 0;
        while (bus.shots_fired != 8'd255 && cycles < 3000) begin
            tick();
            cycles++;
        end
        check("sat_reached", bus.shots_fired, 8'd255);
        check("sat_cycles",  cycles, 1495);
        tick(7);
        check("sat_hold",    bus.shots_fired, 8'd255);

        // Reset in the middle of a handshake.
        bus.spawn_ack = 1'b0;
        wait_spawn("wait_req", 20);
        bus.spawn_ack = 1'b1;
        reset = 1'b1;
        tick();
        bus.spawn_ack = 1'b0;
        check("mid_rst_req",     bus.spawn_req,    1'b0);
        check("mid_rst_drop",    bus.shot_dropped, 1'b0);
        check("mid_rst_shots",   bus.shots_fired,  8'd0);
        check("mid_rst_ovh",     bus.overheated,   1'b0);
        check("mid_rst_ready",   bus.shot_ready,   1'b0);
        bus.fire_request = 1'b0;
        reset = 1'b0;
        tick();
        check("post_rst_ready",  bus.shot_ready,   1'b1);
        check("post_rst_no_req", bus.spawn_req,    1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
